// File: rtl/f1_pkg.sv
// Shared types and default parameter values for the F1 start-light sequencer.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DELAY,
        REACT,
        RESULT,
        FAULT
    } f1_state_t;

    localparam int DEF_N_LIGHTS       = 10;
    localparam int DEF_TICKS_PER_STEP = 1;
    localparam int DEF_DELAY_W        = 14;
    localparam int DEF_MIN_DELAY      = 250;
    localparam int DEF_REACT_W        = 14;

endpackage

// File: rtl/f1_tick_counter.sv
// Tick-enabled counter with synchronous clear and load; counts up or down
// and optionally saturates at its end of range instead of wrapping.
module f1_tick_counter #(
    parameter int W    = 8,
    parameter bit DOWN = 1'b0,
    parameter bit SAT  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count
);

    logic at_limit;

    assign at_limit = DOWN ? (count == '0) : (&count);

    // Count register: clear beats load, load beats the tick enable.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !(SAT && at_limit)) begin
            count <= DOWN ? (count - W'(1)) : (count + W'(1));
        end
    end

endmodule

// File: rtl/f1_start_sequencer.sv
// F1 start-light sequencer: lights lamps one per step, holds for a random
// delay, extinguishes them, then times the driver's reaction or flags a
// jump start.
module f1_start_sequencer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS       = DEF_N_LIGHTS,
    parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
    parameter int DELAY_W        = DEF_DELAY_W,
    parameter int MIN_DELAY      = DEF_MIN_DELAY,
    parameter int REACT_W        = DEF_REACT_W
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic                response,
    input  logic [DELAY_W-1:0]  rand_val,
    output logic                en_lfsr,
    output logic [N_LIGHTS-1:0] ledr,
    output logic                lights_out,
    output logic [REACT_W-1:0]  react_time,
    output logic                react_valid,
    output logic                jump_start,
    output logic                busy
);

    localparam int STEP_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int LIDX_W = $clog2(N_LIGHTS + 1);
    localparam int DCNT_W = DELAY_W + 1;

    f1_state_t state, state_d;

    logic [STEP_W-1:0]   step_cnt;
    logic [DCNT_W-1:0]   delay_cnt;
    logic [REACT_W-1:0]  react_cnt;
    logic [LIDX_W-1:0]   light_idx, light_idx_d;

    logic [N_LIGHTS-1:0] ledr_d;
    logic                lights_out_d;
    logic [REACT_W-1:0]  react_time_d;
    logic                react_valid_d;
    logic                jump_start_d;

    logic                step_clr, step_en;
    logic                delay_load, delay_en;
    logic                react_clr, react_en;
    logic [DCNT_W-1:0]   delay_load_val;

    // One extra bit keeps MIN_DELAY + rand_val from wrapping.
    assign delay_load_val = DCNT_W'(MIN_DELAY) + {1'b0, rand_val};

    assign en_lfsr = (state == IDLE) || (state == COUNT);
    assign busy    = (state == COUNT) || (state == DELAY) || (state == REACT);

    f1_tick_counter #(.W(STEP_W), .DOWN(1'b0), .SAT(1'b0)) u_step_cnt (
        .clk      (sysclk),
        .rst      (rst),
        .clr      (step_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (step_en),
        .count    (step_cnt)
    );

    f1_tick_counter #(.W(DCNT_W), .DOWN(1'b1), .SAT(1'b0)) u_delay_cnt (
        .clk      (sysclk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (delay_load),
        .load_val (delay_load_val),
        .en       (delay_en),
        .count    (delay_cnt)
    );

    f1_tick_counter #(.W(REACT_W), .DOWN(1'b0), .SAT(1'b1)) u_react_cnt (
        .clk      (sysclk),
        .rst      (rst),
        .clr      (react_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (react_en),
        .count    (react_cnt)
    );

    // State register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output and lamp-index registers, loaded from the next-state logic.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            ledr        <= '0;
            light_idx   <= '0;
            lights_out  <= 1'b0;
            react_time  <= '0;
            react_valid <= 1'b0;
            jump_start  <= 1'b0;
        end else begin
            ledr        <= ledr_d;
            light_idx   <= light_idx_d;
            lights_out  <= lights_out_d;
            react_time  <= react_time_d;
            react_valid <= react_valid_d;
            jump_start  <= jump_start_d;
        end
    end

    // Next-state, next-output and counter-control decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d       = state;
        ledr_d        = ledr;
        light_idx_d   = light_idx;
        lights_out_d  = 1'b0;
        react_time_d  = react_time;
        react_valid_d = react_valid;
        jump_start_d  = jump_start;
        step_clr      = 1'b0;
        step_en       = 1'b0;
        delay_load    = 1'b0;
        delay_en      = 1'b0;
        react_clr     = 1'b0;
        react_en      = 1'b0;

        case (state)
            IDLE, RESULT, FAULT: begin
                if (trigger) begin
                    state_d       = COUNT;
                    ledr_d        = '0;
                    react_valid_d = 1'b0;
                    jump_start_d  = 1'b0;
                    light_idx_d   = '0;
                    step_clr      = 1'b1;
                end
            end

            COUNT: begin
                if (response) begin
                    state_d      = FAULT;
                    jump_start_d = 1'b1;
                    ledr_d       = '1;
                end else if (tick) begin
                    if (step_cnt == STEP_W'(TICKS_PER_STEP - 1)) begin
                        // Lamps fill from bit 0 upward, so shifting in a one
                        // lights exactly lamp light_idx.
                        ledr_d      = (ledr << 1) | N_LIGHTS'(1);
                        light_idx_d = light_idx + LIDX_W'(1);
                        step_clr    = 1'b1;
                        if (light_idx == LIDX_W'(N_LIGHTS - 1)) begin
                            delay_load = 1'b1;
                            state_d    = DELAY;
                        end
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end

            DELAY: begin
                if (response) begin
                    state_d      = FAULT;
                    jump_start_d = 1'b1;
                    ledr_d       = '1;
                end else if (tick) begin
                    if (delay_cnt == DCNT_W'(1)) begin
                        ledr_d       = '0;
                        lights_out_d = 1'b1;
                        react_clr    = 1'b1;
                        state_d      = REACT;
                    end else begin
                        delay_en = 1'b1;
                    end
                end
            end

            REACT: begin
                if (response) begin
                    react_time_d  = react_cnt;
                    react_valid_d = 1'b1;
                    state_d       = RESULT;
                end else if (tick) begin
                    if (&react_cnt) begin
                        react_time_d  = '1;
                        react_valid_d = 1'b1;
                        state_d       = RESULT;
                    end else begin
                        react_en = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed testbench for f1_start_sequencer: lamp stepping, lights-out,
// reaction capture, jump starts, reaction timeout and mid-run reset.
module tb_f1_start_sequencer;

    localparam int NL = 5;
    localparam int DW = 14;

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          trigger = 1'b0;
    logic          response = 1'b0;
    logic [DW-1:0] rand_val = DW'(3);

    logic          en_lfsr_a, lights_out_a, react_valid_a, jump_start_a, busy_a;
    logic [NL-1:0] ledr_a;
    logic [13:0]   react_time_a;

    logic          en_lfsr_b, lights_out_b, react_valid_b, jump_start_b, busy_b;
    logic [NL-1:0] ledr_b;
    logic [3:0]    react_time_b;

    int checks = 0;
    int failures = 0;
    int lo_a = 0;
    int lo_before;

    always #5 sysclk = ~sysclk;

    f1_start_sequencer #(
        .N_LIGHTS(NL), .TICKS_PER_STEP(2), .DELAY_W(DW), .MIN_DELAY(4), .REACT_W(14)
    ) dut_a (
        .sysclk(sysclk), .rst(rst), .tick(tick), .trigger(trigger),
        .response(response), .rand_val(rand_val), .en_lfsr(en_lfsr_a),
        .ledr(ledr_a), .lights_out(lights_out_a), .react_time(react_time_a),
        .react_valid(react_valid_a), .jump_start(jump_start_a), .busy(busy_a)
    );

    f1_start_sequencer #(
        .N_LIGHTS(NL), .TICKS_PER_STEP(2), .DELAY_W(DW), .MIN_DELAY(4), .REACT_W(4)
    ) dut_b (
        .sysclk(sysclk), .rst(rst), .tick(tick), .trigger(trigger),
        .response(response), .rand_val(rand_val), .en_lfsr(en_lfsr_b),
        .ledr(ledr_b), .lights_out(lights_out_b), .react_time(react_time_b),
        .react_valid(react_valid_b), .jump_start(jump_start_b), .busy(busy_b)
    );

    // Count lights_out pulses of the wide-counter instance.
    always @(negedge sysclk) begin
        if (lights_out_a) lo_a++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are read 1 ns after.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    // One tick followed by three idle cycles: a tick every 4 cycles.
    task automatic tick4(input int n);
        repeat (n) begin
            tick_pulse();
            cyc(3);
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles.
        cyc(2);
        check("rst_ledr",     32'(ledr_a), 32'h0);
        check("rst_busy",     32'(busy_a), 32'h0);
        check("rst_en_lfsr",  32'(en_lfsr_a), 32'h1);
        check("rst_valid",    32'(react_valid_a), 32'h0);
        check("rst_jump",     32'(jump_start_a), 32'h0);
        check("rst_time",     32'(react_time_a), 32'h0);
        rst = 1'b0;
        cyc(1);

        // Normal run: lamps, lights-out, reaction of 3 ticks.
        pulse_trigger();
        check("count_busy",    32'(busy_a), 32'h1);
        check("count_en_lfsr", 32'(en_lfsr_a), 32'h1);
        tick4(1);
        check("ledr_tick1", 32'(ledr_a), 32'h00);
        tick4(1);
        check("ledr_tick2", 32'(ledr_a), 32'h01);
        tick4(2);
        check("ledr_tick4", 32'(ledr_a), 32'h03);
        tick4(6);
        check("ledr_tick10",    32'(ledr_a), 32'h1f);
        check("delay_en_lfsr",  32'(en_lfsr_a), 32'h0);
        lo_before = lo_a;
        tick4(6);
        check("ledr_delay6", 32'(ledr_a), 32'h1f);
        check("no_lo_yet",   32'(lo_a - lo_before), 32'h0);
        tick_pulse();
        check("lo_pulse",    32'(lights_out_a), 32'h1);
        check("lo_ledr",     32'(ledr_a), 32'h00);
        cyc(1);
        check("lo_one_cycle", 32'(lights_out_a), 32'h0);
        cyc(2);
        check("lo_count",    32'(lo_a - lo_before), 32'h1);
        tick4(3);
        response = 1'b1;
        cyc(1);
        response = 1'b0;
        check("react_time",  32'(react_time_a), 32'd3);
        check("react_valid", 32'(react_valid_a), 32'h1);
        check("react_busy",  32'(busy_a), 32'h0);
        cyc(50);
        response = 1'b1;
        cyc(1);
        response = 1'b0;
        cyc(49);
        check("hold_time",  32'(react_time_a), 32'd3);
        check("hold_valid", 32'(react_valid_a), 32'h1);
        pulse_trigger();
        check("retrig_valid", 32'(react_valid_a), 32'h0);
        check("retrig_time",  32'(react_time_a), 32'd3);
        check("retrig_busy",  32'(busy_a), 32'h1);

        // Jump start in the middle of DELAY.
        lo_before = lo_a;
        tick4(10);
        tick4(3);
        response = 1'b1;
        cyc(1);
        response = 1'b0;
        check("js_flag", 32'(jump_start_a), 32'h1);
        check("js_ledr", 32'(ledr_a), 32'h1f);
        check("js_busy", 32'(busy_a), 32'h0);
        cyc(20);
        check("js_no_lo", 32'(lo_a - lo_before), 32'h0);

        // Jump start on the exact lights-out tick.
        pulse_trigger();
        check("js2_clear", 32'(jump_start_a), 32'h0);
        check("js2_ledr0", 32'(ledr_a), 32'h00);
        lo_before = lo_a;
        tick4(10);
        tick4(6);
        response = 1'b1;
        tick_pulse();
        response = 1'b0;
        check("js2_flag",  32'(jump_start_a), 32'h1);
        check("js2_ledr",  32'(ledr_a), 32'h1f);
        check("js2_lo",    32'(lights_out_a), 32'h0);
        cyc(10);
        check("js2_no_lo", 32'(lo_a - lo_before), 32'h0);

        // Reaction timeout with a 4-bit counter; trigger held through COUNT.
        trigger = 1'b1;
        cyc(1);
        tick4(4);
        check("trig_held_ledr4",  32'(ledr_b), 32'h03);
        tick4(6);
        check("trig_held_ledr10", 32'(ledr_b), 32'h1f);
        trigger = 1'b0;
        tick4(6);
        tick_pulse();
        check("to_lo", 32'(lights_out_b), 32'h1);
        cyc(3);
        tick4(15);
        check("to_not_yet", 32'(react_valid_b), 32'h0);
        tick_pulse();
        check("to_valid", 32'(react_valid_b), 32'h1);
        check("to_time",  32'(react_time_b), 32'hf);
        check("to_busy",  32'(busy_b), 32'h0);
        cyc(3);

        // Reset in the middle of DELAY.
        pulse_trigger();
        tick4(12);
        check("pre_rst_ledr", 32'(ledr_b), 32'h1f);
        check("pre_rst_busy", 32'(busy_b), 32'h1);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_ledr",    32'(ledr_b), 32'h0);
        check("mid_rst_time",    32'(react_time_b), 32'h0);
        check("mid_rst_valid",   32'(react_valid_b), 32'h0);
        check("mid_rst_jump",    32'(jump_start_b), 32'h0);
        check("mid_rst_lo",      32'(lights_out_b), 32'h0);
        check("mid_rst_busy",    32'(busy_b), 32'h0);
        check("mid_rst_en_lfsr", 32'(en_lfsr_b), 32'h1);
        rst = 1'b0;
        cyc(2);
        check("post_rst_idle", 32'(busy_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
